mmul_reg_c_seq: RTL and testbench

- Parametrised, sequenced successor of the modular-multiplier C operand register.
- Holds a (DW+1)-bit operand: DW data bits plus guard/carry bit at index DW.
- Word-serial load and readout use valid/ready handshakes. Multi-bit left shifts run from one command.
- Sits between the 16-bit datapath bus and the Montgomery/modular multiply core. The core consumes `b_top` (bit DW) and the low word.

---
 rtl/mmul_pkg.sv | 30 +++
 rtl/mmul_reg_core.sv | 44 ++++
 rtl/mmul_reg_c_seq.sv | 155 +++++++++++++++
 tb/tb_mmul_reg_c_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// Shared constants for the modular-multiplier C operand register.
// Op codes, FSM state encoding and default operand geometry.
package mmul_pkg;

  localparam int MMUL_DW = 256;
  localparam int MMUL_WW = 16;

  localparam logic [2:0] MMUL_OP_NOP  = 3'd0;
  localparam logic [2:0] MMUL_OP_CLR  = 3'd1;
  localparam logic [2:0] MMUL_OP_LOAD = 3'd2;
  localparam logic [2:0] MMUL_OP_READ = 3'd3;
  localparam logic [2:0] MMUL_OP_ROT  = 3'd4;
  localparam logic [2:0] MMUL_OP_SHL  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_SHL
  } mmul_state_e;

  typedef enum logic [2:0] {
    CORE_HOLD,
    CORE_CLR,
    CORE_ROT,
    CORE_LOAD,
    CORE_SHL
  } mmul_core_op_e;

endpackage

// File: rtl/mmul_reg_core.sv
// (DW+1)-bit C operand storage: right-by-WW rotate / shift-in and left-by-1.
// Zero flag is built only when MMUL_REG_C_ZDET_EN is defined.
module mmul_reg_core
  import mmul_pkg::*;
#(
  parameter int DW = MMUL_DW,
  parameter int WW = MMUL_WW
) (
  input  logic          clk,
  input  logic          rst,
  input  mmul_core_op_e op,
  input  logic [WW-1:0] in_word,
  output logic [DW:0]   r,
  output logic          zero
);

  logic [DW:0] r_nx;

  always_comb begin
    r_nx = r;
    unique case (op)
      CORE_CLR:  r_nx = '0;
      CORE_ROT:  r_nx = {r[DW], r[WW-1:0], r[DW-1:WW]};
      CORE_LOAD: r_nx = {1'b0, in_word, r[DW-1:WW]};
      CORE_SHL:  r_nx = {r[DW-1:0], 1'b0};
      default:   r_nx = r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else     r <= r_nx;
  end

`ifdef MMUL_REG_C_ZDET_EN
  always_ff @(posedge clk) begin
    if (rst) zero <= 1'b1;
    else     zero <= (r_nx == '0);
  end
`else
  assign zero = 1'b0;
`endif

endmodule

// File: rtl/mmul_reg_c_seq.sv
// Sequenced C operand register: word-serial load/readout, multi-bit SHL.
// Optional zero flag enabled by MMUL_REG_C_ZDET_EN.
module mmul_reg_c_seq
  import mmul_pkg::*;
#(
  parameter  int DW = MMUL_DW,
  parameter  int WW = MMUL_WW,
  localparam int NW = DW / WW,
  parameter  int CW = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_arg,
  input  logic [WW-1:0] in_word,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [WW-1:0] out_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          b_top,
  output logic [DW:0]   reg_full,
  output logic          done,
  output logic          reg_zero
);

  // One spare bit so the saturated DW+1 shift count always fits.
  localparam int KW = CW + 1;

  mmul_state_e   st, st_nx;
  mmul_core_op_e cop;
  logic [KW-1:0] cnt, cnt_nx, arg_sat;
  logic          done_nx, last_w;
  logic [DW:0]   r;

  assign arg_sat = (cmd_arg > CW'(DW)) ? KW'(DW + 1)
                                       : KW'(cmd_arg);
  assign last_w  = (cnt == KW'(NW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      st   <= st_nx;
      cnt  <= cnt_nx;
      done <= done_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    done_nx = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (cmd_valid) begin
          done_nx = 1'b1;
          case (cmd_op)
            MMUL_OP_LOAD: begin
              st_nx   = ST_LOAD;
              cnt_nx  = '0;
              done_nx = 1'b0;
            end
            MMUL_OP_READ: begin
              st_nx   = ST_READ;
              cnt_nx  = '0;
              done_nx = 1'b0;
            end
            MMUL_OP_SHL: begin
              cnt_nx = arg_sat;
              if (arg_sat != '0) begin
                st_nx   = ST_SHL;
                done_nx = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          cnt_nx = cnt + 1'b1;
          if (last_w) begin
            st_nx   = ST_IDLE;
            done_nx = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (out_ready) begin
          cnt_nx = cnt + 1'b1;
          if (last_w) begin
            st_nx   = ST_IDLE;
            done_nx = 1'b1;
          end
        end
      end
      ST_SHL: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == KW'(1)) begin
          st_nx   = ST_IDLE;
          done_nx = 1'b1;
        end
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cop       = CORE_HOLD;
    unique case (1'b1)
      (st == ST_IDLE): begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_op == MMUL_OP_CLR)
          cop = CORE_CLR;
        else if (cmd_valid && cmd_op == MMUL_OP_ROT)
          cop = CORE_ROT;
      end
      (st == ST_LOAD): begin
        in_ready = 1'b1;
        if (in_valid) cop = CORE_LOAD;
      end
      (st == ST_READ): begin
        out_valid = 1'b1;
        if (out_ready) cop = CORE_ROT;
      end
      (st == ST_SHL): cop = CORE_SHL;
      default: ;
    endcase
  end

  mmul_reg_core #(
    .DW (DW),
    .WW (WW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .op      (cop),
    .in_word (in_word),
    .r       (r),
    .zero    (reg_zero)
  );

  assign out_word = r[WW-1:0];
  assign b_top    = r[DW];
  assign reg_full = r;

endmodule

// File: tb/tb_mmul_reg_c_seq.sv
// Bench for mmul_reg_c_seq: transaction-level operand model plus per-cycle compare.
// Covers MMUL_REG_C_ZDET_EN checks when the macro is defined.
module tb_mmul_reg_c_seq;
  import mmul_pkg::*;

  localparam int DW = 256;
  localparam int WW = 16;
  localparam int NW = DW / WW;
  localparam int CW = $clog2(DW + 1);
`ifdef MMUL_REG_C_ZDET_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_arg;
  logic [WW-1:0] in_word;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] out_word;
  logic          out_valid;
  logic          out_ready;
  logic          b_top;
  logic [DW:0]   reg_full;
  logic          done;
  logic          reg_zero;

  always #5 clk = ~clk;

  mmul_reg_c_seq #(.DW(DW), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b_top     (b_top),
    .reg_full  (reg_full),
    .done      (done),
    .reg_zero  (reg_zero)
  );

  int          vecs = 0;
  int          errs = 0;
  bit          chk_en = 1'b0;
  logic [DW:0] exp_r;
  logic        exp_ready, exp_in_ready, exp_out_valid, exp_done;
  logic [WW-1:0] got[$];
  logic [WW-1:0] wq[$];
  logic [DW:0] saved;

  task automatic chk(string name, logic [DW:0] act, logic [DW:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 1'b0;
  endtask

  task automatic go_idle();
    exp_ready     = 1'b1;
    exp_in_ready  = 1'b0;
    exp_out_valid = 1'b0;
    exp_done      = 1'b1;
  endtask

  task automatic issue(logic [2:0] op, int arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = CW'(arg);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = MMUL_OP_NOP;
    cmd_arg   = '0;
  endtask

  task automatic op_simple(logic [2:0] op);
    issue(op, 0);
    if (op == MMUL_OP_CLR) exp_r = '0;
    if (op == MMUL_OP_ROT)
      exp_r = {exp_r[DW], exp_r[WW-1:0], exp_r[DW-1:WW]};
    exp_done = 1'b1;
    tick();
  endtask

  // Loads the first n entries of wq; a full load ends back in IDLE.
  task automatic do_load(int n, bit stall);
    issue(MMUL_OP_LOAD, 0);
    exp_ready    = 1'b0;
    exp_in_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (stall && i == 3) begin
        in_valid  = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = MMUL_OP_CLR;
        out_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = MMUL_OP_NOP;
        out_ready = 1'b0;
      end
      in_valid = 1'b1;
      in_word  = wq[i];
      tick();
      in_valid = 1'b0;
      exp_r = {1'b0, wq[i], exp_r[DW-1:WW]};
      if (i == NW - 1) go_idle();
    end
    if (n == NW) tick();
  endtask

  task automatic do_read(bit toggle);
    int k;
    int cyc;
    got.delete();
    issue(MMUL_OP_READ, 0);
    exp_ready     = 1'b0;
    exp_out_valid = 1'b1;
    k   = 0;
    cyc = 0;
    while (k < NW && cyc < 4 * NW) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      if (out_ready) got.push_back(out_word);
      tick();
      if (out_ready) begin
        exp_r = {exp_r[DW], exp_r[WW-1:0], exp_r[DW-1:WW]};
        k++;
        if (k == NW) go_idle();
      end
      cyc++;
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic do_shl(int arg);
    int n;
    n = (arg > DW) ? DW + 1 : arg;
    issue(MMUL_OP_SHL, arg);
    if (n == 0) begin
      exp_done = 1'b1;
    end else begin
      exp_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        tick();
        exp_r = exp_r << 1;
        if (i == n - 1) go_idle();
      end
    end
    tick();
  endtask

  task automatic fill(logic [WW-1:0] lo, logic [WW-1:0] hi);
    wq.delete();
    wq.push_back(lo);
    for (int i = 1; i < NW - 1; i++) wq.push_back('0);
    wq.push_back(hi);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = MMUL_OP_NOP;
    cmd_arg   = '0;
    in_word   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_r         = '0;
    exp_ready     = 1'b1;
    exp_in_ready  = 1'b0;
    exp_out_valid = 1'b0;
    exp_done      = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          vecs++;
          if (reg_full !== exp_r || b_top !== exp_r[DW] ||
              out_word !== exp_r[WW-1:0] ||
              cmd_ready !== exp_ready ||
              in_ready !== exp_in_ready ||
              out_valid !== exp_out_valid ||
              done !== exp_done ||
              reg_zero !== (ZEN && exp_r == '0)) begin
            errs++;
            $display("FAIL cycle t=%0t r=%h/%h rdy=%b/%b inr=%b/%b ov=%b/%b done=%b/%b z=%b/%b",
                     $time, reg_full, exp_r, cmd_ready, exp_ready,
                     in_ready, exp_in_ready, out_valid, exp_out_valid,
                     done, exp_done, reg_zero, (ZEN && exp_r == '0));
          end
        end
      end
    join_none

    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_r", reg_full, '0);
    chk("reset_ready", {256'b0, cmd_ready}, 257'd1);
    chk("reset_zero", {256'b0, reg_zero}, {256'b0, ZEN});

    // Load 0x0001..0x0010 with a stall, busy cmd_valid and stray out_ready.
    wq.delete();
    for (int i = 1; i <= NW; i++) wq.push_back(WW'(i));
    do_load(NW, 1'b1);
    chk("load_full", reg_full,
        257'h0_0010_000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001);
    chk("load_btop", {256'b0, b_top}, '0);
    saved = reg_full;

    do_read(1'b1);
    for (int i = 0; i < NW; i++)
      chk($sformatf("read_w%0d", i), {241'b0, got[i]}, DW'(i + 1));
    chk("read_nondestr", reg_full, saved);

    op_simple(MMUL_OP_NOP);
    op_simple(3'd6);
    op_simple(3'd7);

    fill(16'h0000, 16'h8000);
    do_load(NW, 1'b0);
    do_shl(1);
    chk("shl1_btop", {256'b0, b_top}, 257'd1);
    chk("shl1_full", reg_full, {1'b1, 256'b0});
    do_shl(1);
    chk("shl1_again", reg_full, '0);

    fill(16'hABCD, 16'h0000);
    do_load(NW, 1'b0);
    op_simple(MMUL_OP_ROT);
    chk("rot_top", {241'b0, reg_full[255:240]}, 257'hABCD);
    chk("rot_btop0", {256'b0, b_top}, '0);

    fill(16'hABCD, 16'hC000);
    do_load(NW, 1'b0);
    do_shl(1);
    op_simple(MMUL_OP_ROT);
    chk("rot_top2", {241'b0, reg_full[255:240]}, 257'h579A);
    chk("rot_btop1", {256'b0, b_top}, 257'd1);
    saved = reg_full;
    do_shl(0);
    chk("shl0_same", reg_full, saved);

    // Reset in the middle of a load.
    wq.delete();
    for (int i = 1; i <= NW; i++) wq.push_back(WW'(16'h1100 + i));
    do_load(5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_r         = '0;
    exp_ready     = 1'b1;
    exp_in_ready  = 1'b0;
    exp_out_valid = 1'b0;
    chk("rst_mid_r", reg_full, '0);
    chk("rst_mid_inr", {256'b0, in_ready}, '0);
    tick();

    fill(16'h0001, 16'h0000);
    do_load(NW, 1'b0);
    op_simple(MMUL_OP_CLR);
    chk("clr_zero", {256'b0, reg_zero}, {256'b0, ZEN});
    do_load(NW, 1'b0);
    chk("ld1_zero", {256'b0, reg_zero}, '0);
    do_shl(256);
    chk("shl256", reg_full, {1'b1, 256'b0});
    do_shl(300);
    chk("shl300", reg_full, '0);
    chk("shl300_zero", {256'b0, reg_zero}, {256'b0, ZEN});

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
